// File: rtl/nec_ir_pkg.sv
// NEC IR transmitter shared types and timing constants.
// Durations are in NEC time units.
package nec_ir_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_RPT_SPACE,
    S_STOP_MARK,
    S_GAP
  } state_e;

  localparam int LEAD_MARK_U  = 16;
  localparam int LEAD_SPACE_U = 8;
  localparam int BIT_MARK_U   = 1;
  localparam int ZERO_SPACE_U = 1;
  localparam int ONE_SPACE_U  = 3;
  localparam int RPT_SPACE_U  = 4;
  localparam int STOP_U       = 1;
  localparam int NBITS        = 32;

  function automatic logic is_mark(state_e s);
    return (s == S_LEAD_MARK) ||
           (s == S_BIT_MARK)  ||
           (s == S_STOP_MARK);
  endfunction

endpackage

// File: rtl/nec_carrier_gen.sv
// IR carrier square wave, restarted high at each mark entry.
// Inputs describe the cycle after the clock edge, so carrier is aligned with the envelope register.
module nec_carrier_gen #(
  parameter int CARRIER_HALF = 658
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic carrier
);

  localparam int PW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  logic [PW-1:0] phase_q, phase_d;
  logic          car_q, car_d;

  always_comb begin
    phase_d = phase_q;
    car_d   = car_q;
    if (restart) begin
      phase_d = '0;
      car_d   = 1'b1;
    end else if (enable) begin
      if (phase_q == PW'(CARRIER_HALF - 1)) begin
        phase_d = '0;
        car_d   = ~car_q;
      end else begin
        phase_d = phase_q + PW'(1);
      end
    end else begin
      phase_d = '0;
      car_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      car_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      car_q   <= car_d;
    end
  end

  assign carrier = car_q;

endmodule

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: frame or repeat code in a fixed-length slot.
// Outputs are registered from next-state values.
module nec_ir_tx
  import nec_ir_pkg::*;
#(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658,
  parameter int FRAME_UNITS  = 192
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rpt,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       ir_env,
  output logic       ir_out
);

  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int SW = (FRAME_UNITS > 1) ? $clog2(FRAME_UNITS) : 1;

  state_e        state_q, state_d;
  logic [UW-1:0] unit_q, unit_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [4:0]    su_q, su_d;
  logic [4:0]    dur_last;
  logic [31:0]   shift_q, shift_d;
  logic [4:0]    idx_q, idx_d;
  logic          rpt_q, rpt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          env_q, env_d;
  logic          unit_tick;
  logic          seg_end;
  logic          slot_end;
  logic          car_restart;
  logic          carrier;

  assign unit_tick = (unit_q == UW'(UNIT_CYCLES - 1));
  assign slot_end  = unit_tick && (slot_q == SW'(FRAME_UNITS - 1));
  assign seg_end   = unit_tick && (su_q == dur_last);

  always_comb begin
    dur_last = '0;
    unique case (state_q)
      S_LEAD_MARK:  dur_last = 5'(LEAD_MARK_U - 1);
      S_LEAD_SPACE: dur_last = 5'(LEAD_SPACE_U - 1);
      S_BIT_MARK:   dur_last = 5'(BIT_MARK_U - 1);
      S_BIT_SPACE:  dur_last = shift_q[0] ? 5'(ONE_SPACE_U - 1)
                                          : 5'(ZERO_SPACE_U - 1);
      S_RPT_SPACE:  dur_last = 5'(RPT_SPACE_U - 1);
      S_STOP_MARK:  dur_last = 5'(STOP_U - 1);
      default:      dur_last = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    slot_d  = slot_q;
    su_d    = su_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    rpt_d   = rpt_q;
    if (state_q == S_IDLE) begin
      unit_d = '0;
      slot_d = '0;
      su_d   = '0;
      // start has priority over rpt
      if (start) begin
        shift_d = {~cmd, cmd, ~addr, addr};
        rpt_d   = 1'b0;
        state_d = S_LEAD_MARK;
      end else if (rpt) begin
        rpt_d   = 1'b1;
        state_d = S_LEAD_MARK;
      end
    end else begin
      unit_d = unit_tick ? '0 : unit_q + UW'(1);
      if (unit_tick) begin
        slot_d = slot_q + SW'(1);
        su_d   = su_q + 5'd1;
      end
      unique case (state_q)
        S_LEAD_MARK:
          if (seg_end) state_d = rpt_q ? S_RPT_SPACE : S_LEAD_SPACE;
        S_LEAD_SPACE:
          if (seg_end) begin
            idx_d   = '0;
            state_d = S_BIT_MARK;
          end
        S_BIT_MARK:
          if (seg_end) state_d = S_BIT_SPACE;
        S_BIT_SPACE:
          if (seg_end) begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 5'd1;
            state_d = (idx_q == 5'(NBITS - 1)) ? S_STOP_MARK : S_BIT_MARK;
          end
        S_RPT_SPACE:
          if (seg_end) state_d = S_STOP_MARK;
        S_STOP_MARK:
          if (seg_end) state_d = S_GAP;
        S_GAP:
          if (slot_end) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) su_d = '0;
      if (state_d == S_IDLE) begin
        slot_d = '0;
        unit_d = '0;
      end
    end
  end

  // done is set for the cycle that will be the final one of the slot
  always_comb begin
    env_d  = is_mark(state_d);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_GAP) &&
             (unit_d == UW'(UNIT_CYCLES - 1)) &&
             (slot_d == SW'(FRAME_UNITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      unit_q  <= '0;
      slot_q  <= '0;
      su_q    <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      rpt_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      env_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      slot_q  <= slot_d;
      su_q    <= su_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      rpt_q   <= rpt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      env_q   <= env_d;
    end
  end

  assign car_restart = env_d && !env_q;

  nec_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF)
  ) u_carrier (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(car_restart),
    .enable (env_d),
    .carrier(carrier)
  );

  assign busy   = busy_q;
  assign done   = done_q;
  assign ir_env = env_q;
  // carrier is forced low whenever the envelope is low
  assign ir_out = carrier;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Bench for nec_ir_tx: a slot-level waveform model checked every cycle,
// plus envelope decoding and literal timing checks.
module tb_nec_ir_tx;

  localparam int UNIT  = 4;
  localparam int HALF  = 1;
  localparam int FRAME = 192;
  localparam int SLOT  = FRAME * UNIT;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       start = 0;
  logic       rpt = 0;
  logic [7:0] addr = 0;
  logic [7:0] cmd = 0;
  logic       busy, done, ir_env, ir_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nec_ir_tx #(
    .UNIT_CYCLES (UNIT),
    .CARRIER_HALF(HALF),
    .FRAME_UNITS (FRAME)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .rpt   (rpt),
    .addr  (addr),
    .cmd   (cmd),
    .busy  (busy),
    .done  (done),
    .ir_env(ir_env),
    .ir_out(ir_out)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  bit env_exp[SLOT];
  bit car_exp[SLOT];
  int wp;

  task automatic seg(input bit lvl, input int units);
    for (int k = 0; k < units * UNIT; k++) begin
      env_exp[wp] = lvl;
      car_exp[wp] = lvl && (((k / HALF) % 2) == 0);
      wp++;
    end
  endtask

  task automatic build(input bit is_rpt, input logic [7:0] a,
                       input logic [7:0] c);
    logic [31:0] w;
    for (int i = 0; i < SLOT; i++) begin
      env_exp[i] = 0;
      car_exp[i] = 0;
    end
    wp = 0;
    seg(1, 16);
    if (is_rpt) begin
      seg(0, 4);
    end else begin
      seg(0, 8);
      w = {~c, c, ~a, a};
      for (int i = 0; i < 32; i++) begin
        seg(1, 1);
        seg(0, w[i] ? 3 : 1);
      end
    end
    seg(1, 1);
  endtask

  function automatic int env_ones();
    int n = 0;
    for (int i = 0; i < SLOT; i++) n += int'(env_exp[i]);
    return n;
  endfunction

  int pos = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos = 0;
    else if (pos == 0) begin
      if (start) begin
        build(0, addr, cmd);
        pos = 1;
      end else if (rpt) begin
        build(1, addr, cmd);
        pos = 1;
      end
    end else if (pos == SLOT) pos = 0;
    else pos++;
  end

  always @(negedge clk) begin : cmp
    logic [3:0] exp_v;
    if (pos == 0) exp_v = 4'b0;
    else exp_v = {1'b1, pos == SLOT, env_exp[pos-1], car_exp[pos-1]};
    chk("busy_done_env_out", {28'b0, busy, done, ir_env, ir_out},
        {28'b0, exp_v});
  end

  int          run = 0, last_mark = 0, lead_sp = 0, dec_n = 0;
  logic [31:0] dec_word = 0;
  bit          prev = 0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run = 0;
      prev = 0;
      last_mark = 0;
    end else if (ir_env == prev) run++;
    else begin
      if (ir_env) begin
        if (last_mark == 64) begin
          lead_sp = run;
          dec_n = 0;
          dec_word = 0;
        end else if (last_mark == 4 && dec_n < 32 &&
                     (run == 4 || run == 12)) begin
          dec_word[dec_n] = (run == 12);
          dec_n++;
        end
      end else last_mark = run;
      run = 1;
      prev = ir_env;
    end
  end

  int  n_rise = 0, n_done = 0;
  time rise_last = 0, rise_prev = 0;
  bit  busy_d1 = 0;

  always @(negedge clk) begin
    if (busy && !busy_d1) begin
      rise_prev = rise_last;
      rise_last = $time;
      n_rise++;
    end
    if (done) n_done++;
    busy_d1 = busy;
  end

  task automatic wait_idle(output int bcnt);
    bcnt = 0;
    for (int k = 0; k < 1000 && busy; k++) begin
      bcnt++;
      @(negedge clk);
    end
    chk("slot_timeout", {31'b0, busy}, 0);
  endtask

  task automatic run_slot(input bit s, input bit r, input logic [7:0] a,
                          input logic [7:0] c, input bit noise,
                          output int bcnt);
    @(negedge clk);
    start = s;
    rpt = r;
    addr = a;
    cmd = c;
    @(negedge clk);
    start = 0;
    rpt = 0;
    bcnt = 0;
    for (int k = 0; k < 1000 && busy; k++) begin
      bcnt++;
      if (noise && k == 300) begin
        start = 1;
        rpt = 1;
        addr = 8'($urandom);
        cmd = 8'($urandom);
      end else begin
        start = 0;
        rpt = 0;
      end
      @(negedge clk);
    end
    start = 0;
    rpt = 0;
    chk("slot_timeout", {31'b0, busy}, 0);
  endtask

  initial begin
    int bc, nr0, nd0, kind;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    run_slot(1, 0, 8'h00, 8'h00, 0, bc);
    chk("f00_busy_len", bc, 768);
    chk("f00_model_ones", env_ones(), 196);
    chk("f00_model_lead_end", {31'b0, env_exp[63]}, 1);
    chk("f00_model_space", {31'b0, env_exp[64]}, 0);
    chk("f00_model_bit0", {31'b0, env_exp[96]}, 1);
    chk("f00_model_car", {30'b0, car_exp[0], car_exp[1]}, 2'b10);
    chk("f00_lead_space", lead_sp, 32);

    run_slot(1, 0, 8'h59, 8'hA6, 0, bc);
    chk("f59_dec_n", dec_n, 32);
    chk("f59_dec_word", dec_word, 32'h59A6A659);

    run_slot(0, 1, 8'h12, 8'h34, 1, bc);
    chk("rpt_busy_len", bc, 768);
    chk("rpt_lead_space", lead_sp, 16);
    chk("rpt_model_ones", env_ones(), 68);

    run_slot(1, 1, 8'hC3, 8'h3C, 0, bc);
    chk("both_lead_space", lead_sp, 32);
    chk("both_dec_word", dec_word, 32'hC33C3CC3);

    @(negedge clk);
    start = 1;
    addr = 8'($urandom);
    cmd = 8'($urandom);
    nr0 = n_rise;
    nd0 = n_done;
    repeat (769 * 3 - 100) @(negedge clk);
    start = 0;
    wait_idle(bc);
    chk("b2b_period", int'((rise_last - rise_prev) / 10), 769);
    chk("b2b_frames", n_rise - nr0, 3);
    chk("b2b_dones", n_done - nd0, 3);

    nd0 = n_done;
    @(negedge clk);
    start = 1;
    addr = 8'h00;
    cmd = 8'h00;
    @(negedge clk);
    start = 0;
    repeat (176) @(negedge clk);
    chk("bit10_env", {31'b0, ir_env}, 1);
    #3 rst_n = 0;
    #1;
    chk("rst_env", {31'b0, ir_env}, 0);
    chk("rst_out", {31'b0, ir_out}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    repeat (3) @(negedge clk);
    chk("rst_no_done", n_done - nd0, 0);
    rst_n = 1;
    run_slot(1, 0, 8'h5A, 8'h0F, 0, bc);
    chk("post_rst_busy_len", bc, 768);
    chk("post_rst_lead_space", lead_sp, 32);

    for (int i = 0; i < 10; i++) begin
      kind = int'($urandom_range(0, 2));
      run_slot(kind != 1, kind != 0, 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 1)), bc);
      chk("rnd_busy_len", bc, 768);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
